hdlc_onehot_deframer: RTL

- Parametrised, registered successor to the team's combinational one-hot bit-run FSM.
- Tracks runs of consecutive 1s on a serial bit stream.
- Detects stuffed zeros, flags and aborts, and removes the stuffed zeros from the data stream.
- Adds an input valid qualifier, frame-sync tracking, illegal-state recovery and saturating event counters.
- Sits between the serial line receiver and the frame/byte assembly layer.

---
 rtl/hdlc_pkg.sv | 26 ++
 rtl/sat_counter.sv | 24 ++
 rtl/hdlc_onehot_deframer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC one-hot deframer: default parameters and
// the mapping from logical states to one-hot bit positions.
package hdlc_pkg;

    localparam int STUFF_RUN_DEF = 5;
    localparam int CNT_W_DEF     = 16;

    // ONESk occupies bit k.
    function automatic int ones_idx(input int k);
        return k;
    endfunction

    // ERR is the run one past a flag's run of ones.
    function automatic int err_idx(input int stuff_run);
        return stuff_run + 2;
    endfunction

    function automatic int disc_idx(input int stuff_run);
        return stuff_run + 3;
    endfunction

    function automatic int flag_idx(input int stuff_run);
        return stuff_run + 4;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a clear that wins over
// a simultaneous increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count events, sticking at all-ones; clear beats increment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdlc_onehot_deframer.sv
// One-hot HDLC bit-run tracker: detects stuffed zeros, flags and aborts,
// removes stuffed zeros from the data stream, tracks frame sync and counts
// events. The state register recovers to ONES0 from any non-one-hot value.
module hdlc_onehot_deframer
    import hdlc_pkg::*;
#(
    parameter  int STUFF_RUN = STUFF_RUN_DEF,
    parameter  int CNT_W     = CNT_W_DEF,
    localparam int N_ST      = STUFF_RUN + 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cnt_clr,
    output logic [N_ST-1:0]  state,
    output logic             flag,
    output logic             disc,
    output logic             err,
    output logic             state_err,
    output logic             in_frame,
    output logic             out_valid,
    output logic             out_bit,
    output logic [CNT_W-1:0] flag_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int ERR  = err_idx(STUFF_RUN);
    localparam int DISC = disc_idx(STUFF_RUN);
    localparam int FLAG = flag_idx(STUFF_RUN);
    localparam logic [N_ST-1:0] ST_ONES0 = N_ST'(1);

    if (STUFF_RUN < 2) begin : g_bad_param
        $error("hdlc_onehot_deframer: STUFF_RUN must be at least 2");
    end

    logic [N_ST-1:0] nxt;
    logic            zero_src;
    logic            legal;
    logic            enter_flag;
    logic            enter_disc;
    logic            enter_err;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign legal = (state != '0) && ((state & (state - 1'b1)) == '0);

    // Next state built per bit by OR-ing every predecessor that leads to it.
    always_comb begin
        // NOTE: combinational logic uses blocking assignment with a full
        // default first, so later terms see earlier ones and no latch forms.
        nxt      = '0;
        zero_src = state[ERR] | state[DISC] | state[FLAG];
        for (int k = 0; k < STUFF_RUN; k++) begin
            zero_src = zero_src | state[ones_idx(k)];
        end
        for (int k = 1; k <= STUFF_RUN + 1; k++) begin
            nxt[ones_idx(k)] = in_bit & state[ones_idx(k - 1)];
        end
        nxt[ones_idx(1)] = nxt[ones_idx(1)] | (in_bit & (state[DISC] | state[FLAG]));
        nxt[ERR]         = in_bit & (state[ones_idx(STUFF_RUN + 1)] | state[ERR]);
        nxt[DISC]        = ~in_bit & state[ones_idx(STUFF_RUN)];
        nxt[FLAG]        = ~in_bit & state[ones_idx(STUFF_RUN + 1)];
        nxt[ones_idx(0)] = ~in_bit & zero_src;
    end

    // Events are counted once per entry; staying in ERR is not a new abort.
    assign enter_flag = in_valid & legal & nxt[FLAG];
    assign enter_disc = in_valid & legal & nxt[DISC];
    assign enter_err  = in_valid & legal & nxt[ERR] & ~state[ERR];

    // State, frame sync and destuffed data register, with illegal-state recovery.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ONES0;
            state_err <= 1'b0;
            in_frame  <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (!legal) begin
            state     <= ST_ONES0;
            state_err <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_err <= 1'b0;
            out_valid <= 1'b0;
            if (in_valid) begin
                state     <= nxt;
                out_valid <= in_frame & ~nxt[DISC];
                out_bit   <= in_bit;
                if (nxt[FLAG]) begin
                    in_frame <= 1'b1;
                end else if (nxt[ERR]) begin
                    in_frame <= 1'b0;
                end
            end
        end
    end

    assign flag = state[FLAG];
    assign disc = state[DISC];
    assign err  = state[ERR];

    sat_counter #(.W(CNT_W)) u_flag_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (enter_flag),
        .cnt  (flag_cnt)
    );

    sat_counter #(.W(CNT_W)) u_disc_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (enter_disc),
        .cnt  (disc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (enter_err),
        .cnt  (err_cnt)
    );

endmodule
